// File: rtl/ps2_link_pkg.sv
// Shared constants and FSM state type for the Arduino<->FPGA controller link.
// Used by both the transmit and the receive block.
package ps2_link_pkg;

  localparam int NUM_BUTTONS = 10;

  localparam logic [3:0] CODE_NONE     = 4'd0;
  localparam logic [3:0] CODE_CIRCLE   = 4'd1;
  localparam logic [3:0] CODE_CROSS    = 4'd2;
  localparam logic [3:0] CODE_SQUARE   = 4'd3;
  localparam logic [3:0] CODE_TRIANGLE = 4'd4;
  localparam logic [3:0] CODE_LEFT     = 4'd5;
  localparam logic [3:0] CODE_RIGHT    = 4'd6;
  localparam logic [3:0] CODE_UP       = 4'd7;
  localparam logic [3:0] CODE_DOWN     = 4'd8;
  localparam logic [3:0] CODE_R1       = 4'd9;
  localparam logic [3:0] CODE_START    = 4'd10;

  localparam int BTN_CIRCLE   = 0;
  localparam int BTN_CROSS    = 1;
  localparam int BTN_SQUARE   = 2;
  localparam int BTN_TRIANGLE = 3;
  localparam int BTN_LEFT     = 4;
  localparam int BTN_RIGHT    = 5;
  localparam int BTN_UP       = 6;
  localparam int BTN_DOWN     = 7;
  localparam int BTN_R1       = 8;
  localparam int BTN_START    = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    GAP
  } tx_state_t;

endpackage

// File: rtl/ps2_btn_encoder.sv
// Lowest-set-bit encoder: button vector -> {valid, code}.
// Bit k maps to code k+1; an empty vector gives CODE_NONE.
module ps2_btn_encoder
  import ps2_link_pkg::*;
(
  input  logic [NUM_BUTTONS-1:0] btn,
  output logic                   valid,
  output logic [3:0]             code
);

  always_comb begin
    valid = 1'b0;
    code  = CODE_NONE;
    for (int k = NUM_BUTTONS - 1; k >= 0; k--) begin
      if (btn[k]) begin
        valid = 1'b1;
        code  = 4'(k + 1);
      end
    end
  end

endmodule

// File: rtl/ps2_link_tx.sv
// Serialises pressed buttons of two controllers onto GPIO as held codes.
// Define PS2_TX_REPEAT_EN for continuous retransmission of held buttons.
module ps2_link_tx
  import ps2_link_pkg::*;
#(
  parameter int HOLD_CYCLES = 1_100_000,
  parameter int GAP_CYCLES  = 1_000,
  parameter int CNT_W       = 21
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] c1,
  input  logic [NUM_BUTTONS-1:0] c2,
  output logic [4:0]             gpio_out,
  output logic                   busy,
  output logic                   frame_done
);

  tx_state_t state, state_n;

  logic [NUM_BUTTONS-1:0] snap1, snap2;
  logic [CNT_W-1:0]       cnt;
  logic                   sel;
  logic [3:0]             code;
  logic                   v1, v2;
  logic [3:0]             code1, code2;
  logic                   start;
  logic                   hold_end, gap_end;

  ps2_btn_encoder u_enc1 (
    .btn   (snap1),
    .valid (v1),
    .code  (code1)
  );

  ps2_btn_encoder u_enc2 (
    .btn   (snap2),
    .valid (v2),
    .code  (code2)
  );

`ifdef PS2_TX_REPEAT_EN
  assign start = ({c2, c1} != '0);
`else
  logic [2*NUM_BUTTONS-1:0] last_sent, frame_snap;
  // An unchanged held vector is not resent until it changes or is released
  assign start = ({c2, c1} != '0) && ({c2, c1} != last_sent);
`endif

  assign hold_end = (cnt == CNT_W'(HOLD_CYCLES - 1));
  assign gap_end  = (cnt == CNT_W'(GAP_CYCLES - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = LOAD;
      LOAD: state_n = (v1 || v2) ? HOLD : IDLE;
      HOLD: if (hold_end) state_n = GAP;
      GAP:  if (gap_end) state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      snap1      <= '0;
      snap2      <= '0;
      cnt        <= '0;
      sel        <= 1'b0;
      code       <= CODE_NONE;
      gpio_out   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifndef PS2_TX_REPEAT_EN
      last_sent  <= '0;
      frame_snap <= '0;
`endif
    end else begin
      state      <= state_n;
      busy       <= (state_n != IDLE);
      frame_done <= 1'b0;

      unique case (state)
        HOLD:    gpio_out <= {sel, code};
        GAP:     gpio_out <= {sel, CODE_NONE};
        default: gpio_out <= '0;
      endcase

      unique case (state)
        IDLE: begin
          if (start) begin
            snap1 <= c1;
            snap2 <= c2;
          end
`ifndef PS2_TX_REPEAT_EN
          if (start) frame_snap <= {c2, c1};
          if ({c2, c1} == '0) last_sent <= '0;
`endif
        end
        LOAD: begin
          cnt <= '0;
          if (v1) begin
            sel  <= 1'b0;
            code <= code1;
          end else if (v2) begin
            sel  <= 1'b1;
            code <= code2;
          end else begin
            frame_done <= 1'b1;
`ifndef PS2_TX_REPEAT_EN
            last_sent  <= frame_snap;
`endif
          end
        end
        HOLD: cnt <= hold_end ? '0 : cnt + 1'b1;
        GAP: begin
          cnt <= cnt + 1'b1;
          // Drop the button just sent: clear the lowest set bit
          if (gap_end) begin
            if (!sel) snap1 <= snap1 & (snap1 - 1'b1);
            else      snap2 <= snap2 & (snap2 - 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_link_tx.sv
// Self-checking bench for ps2_link_tx with short hold/gap timing.
// Expected GPIO streams are built from the button vectors by a list model.
module tb_ps2_link_tx;

  localparam int H = 8;
  localparam int G = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] c1, c2;
  logic [4:0] gpio_out;
  logic       busy;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_link_tx #(
    .HOLD_CYCLES (H),
    .GAP_CYCLES  (G),
    .CNT_W       (21)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .c1         (c1),
    .c2         (c2),
    .gpio_out   (gpio_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Drives a,b from idle and follows the whole frame cycle by cycle.
  // chg_at >= 0 rewrites c1 to chg_val before that sample (must not matter).
  task automatic run_frame(input logic [9:0] a, input logic [9:0] b,
                           input int chg_at, input logic [9:0] chg_val,
                           input string tag);
    logic [4:0] exp[$];
    logic       last;
    exp.push_back(5'h00);
    for (int k = 0; k < 10; k++)
      if (a[k]) begin
        repeat (H) exp.push_back({1'b0, 4'(k + 1)});
        repeat (G) exp.push_back(5'h00);
        exp.push_back(5'h00);
      end
    for (int k = 0; k < 10; k++)
      if (b[k]) begin
        repeat (H) exp.push_back({1'b1, 4'(k + 1)});
        repeat (G) exp.push_back(5'h10);
        exp.push_back(5'h00);
      end
    c1 = a;
    c2 = b;
    cyc();
    n_checks++;
    if (busy !== 1'b1 || gpio_out !== 5'h00 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start: busy=%b gpio=%h fd=%b, want 1 00 0",
               tag, busy, gpio_out, frame_done);
    end
    for (int i = 0; i < exp.size(); i++) begin
      if (i == chg_at) c1 = chg_val;
      cyc();
      last = (i == exp.size() - 1);
      n_checks++;
      if (gpio_out !== exp[i] || busy !== !last || frame_done !== last) begin
        n_fail++;
        $display("FAIL %s step %0d: gpio=%h busy=%b fd=%b, want %h %b %b",
                 tag, i, gpio_out, busy, frame_done, exp[i], !last, last);
      end
    end
  endtask

  task automatic test_idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc();
      n_checks++;
      if (busy !== 1'b0 || gpio_out !== 5'h00 || frame_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s idle %0d: busy=%b gpio=%h fd=%b, want 0 00 0",
                 tag, i, busy, gpio_out, frame_done);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    c1 = 10'h3ff;
    c2 = 10'h3ff;
    test_idle(3, "reset");
    c1 = '0;
    c2 = '0;
    reset = 1'b0;
    test_idle(2, "post_reset");
  endtask

  task automatic test_single();
    run_frame(10'h001, 10'h000, -1, 10'h000, "single");
    c1 = '0;
    test_idle(2, "single_after");
  endtask

  task automatic test_order();
    run_frame(10'h201, 10'h040, -1, 10'h000, "order");
    c1 = '0;
    c2 = '0;
    test_idle(2, "order_after");
  endtask

  task automatic test_mid_change();
    run_frame(10'h003, 10'h000, 4, 10'h010, "midchg");
    run_frame(10'h010, 10'h000, -1, 10'h000, "midchg_new");
    c1 = '0;
    test_idle(2, "midchg_after");
  endtask

  task automatic test_reset_mid();
    c1 = 10'h004;
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    n_checks++;
    if (busy !== 1'b0 || gpio_out !== 5'h00 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: busy=%b gpio=%h fd=%b, want 0 00 0",
               busy, gpio_out, frame_done);
    end
    reset = 1'b0;
    run_frame(10'h004, 10'h000, -1, 10'h000, "reset_restart");
    c1 = '0;
    test_idle(2, "reset_restart_after");
  endtask

  task automatic test_hold_const();
    run_frame(10'h000, 10'h200, -1, 10'h000, "hold1");
`ifdef PS2_TX_REPEAT_EN
    run_frame(10'h000, 10'h200, -1, 10'h000, "hold2");
    run_frame(10'h000, 10'h200, -1, 10'h000, "hold3");
    c2 = '0;
    test_idle(2, "hold_after");
`else
    test_idle(20, "hold_once");
    c2 = '0;
    test_idle(2, "hold_after");
`endif
  endtask

  task automatic test_random();
    logic [9:0] a, b;
    for (int n = 0; n < 8; n++) begin
      a = 10'($urandom & $urandom);
      b = 10'($urandom & $urandom);
      if (a == 0 && b == 0) a = 10'h100;
      run_frame(a, b, n, 10'($urandom), "random");
      c1 = '0;
      c2 = '0;
      test_idle(2, "random_after");
    end
  endtask

  initial begin
    reset = 1'b1;
    c1 = '0;
    c2 = '0;
    @(negedge clock);
    test_reset();
    test_single();
    test_order();
    test_mid_change();
    test_reset_mid();
    test_hold_const();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
